// File: rtl/otter_pkg.sv
// otter_pkg: shared register-address and register-mask types
package otter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [NUM_REGS-1:0] reg_mask_t;
endpackage

// File: rtl/pending_counter.sv
// pending_counter: saturating up/down count of outstanding writes to one register
module pending_counter #(
  parameter int CNT_W = 2
) (
  input  logic CLK,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output logic is_zero,
  output logic is_max
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign is_zero = cnt_q == '0;
  assign is_max = &cnt_q;
  // clear wins; inc and dec together cancel; never wraps at either end
  always_comb
    cnt_d = clear ? '0
          : (inc && !dec && !is_max) ? cnt_q + 1'b1
          : (dec && !inc && !is_zero) ? cnt_q - 1'b1
          : cnt_q;
  // count register
  always_ff @(posedge CLK)
    cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: stalls decode while a source register still has a write outstanding
module reg_scoreboard
  import otter_pkg::reg_addr_t;
  import otter_pkg::REG_ADDR_W;
#(
  parameter int NUM_REGS = 32,
  parameter int CNT_W = 2
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                issue_valid,
  input  reg_addr_t           issue_rs1,
  input  reg_addr_t           issue_rs2,
  input  logic                issue_use_rs1,
  input  logic                issue_use_rs2,
  input  reg_addr_t           issue_rd,
  input  logic                issue_wr_en,
  output logic                issue_ready,
  output logic                stall,
  input  logic                wb_valid,
  input  reg_addr_t           wb_rd,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                idle,
  output logic                underflow_err
);
  logic [NUM_REGS-1:0] zero, full, inc;
  logic src_hit1, src_hit2, sat, accept, uf_hit, underflow_q, underflow_d;
  assign zero[0] = 1'b1;
  assign full[0] = 1'b0;
  assign inc[0] = 1'b0;
  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_cnt
      logic dec;
      assign inc[r] = accept && issue_wr_en && issue_rd == REG_ADDR_W'(r);
      assign dec = wb_valid && wb_rd == REG_ADDR_W'(r) && !zero[r];
      pending_counter #(.CNT_W(CNT_W)) u_cnt (
        .CLK     (CLK),
        .rst     (rst),
        .clear   (flush),
        .inc     (inc[r]),
        .dec     (dec),
        .is_zero (zero[r]),
        .is_max  (full[r])
      );
    end
  endgenerate
  // a same-cycle writeback does not clear a hit: the file only updates on the edge
  always_comb begin
    src_hit1 = issue_use_rs1 && issue_rs1 != '0 && !zero[issue_rs1];
    src_hit2 = issue_use_rs2 && issue_rs2 != '0 && !zero[issue_rs2];
    sat = issue_wr_en && issue_rd != '0 && full[issue_rd];
    issue_ready = !flush && !src_hit1 && !src_hit2 && !sat;
    accept = issue_valid && issue_ready;
    stall = issue_valid && !issue_ready;
  end
  // retiring a write that was never issued is a pipeline bug; latch it until reset
  always_comb begin
    uf_hit = wb_valid && wb_rd != '0 && zero[wb_rd] && !inc[wb_rd];
    underflow_d = underflow_q || uf_hit;
  end
  // sticky underflow flag
  always_ff @(posedge CLK)
    underflow_q <= rst ? 1'b0 : underflow_d;
  assign busy_vec = ~zero;
  assign idle = &zero;
  assign underflow_err = underflow_q;
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks register writes that have been issued but not yet written back to RegisterFile32x32.
- Sits in decode, in front of the register-file read ports.
- Stalls any instruction whose source registers still have a write outstanding, so the asynchronous read port returns the new value, not a stale one.
- Pipeline issues writes on one side; the writeback port retires them on the other.

Parameters:
- NUM_REGS, 32, number of architectural registers; x0 is never tracked.
- CNT_W, 2, width of each per-register pending counter; at most 2^CNT_W-1 outstanding writes per register.

Ports:
- CLK  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction.
- issue_rs1  in  5  source register 1 address.
- issue_rs2  in  5  source register 2 address.
- issue_use_rs1  in  1  instruction reads rs1.
- issue_use_rs2  in  1  instruction reads rs2.
- issue_rd  in  5  destination register address.
- issue_wr_en  in  1  instruction writes rd.
- issue_ready  out  1  instruction accepted this cycle.
- stall  out  1  issue_valid && !issue_ready.
- wb_valid  in  1  writeback retires a write (same strobe as the register-file EN).
- wb_rd  in  5  retired destination (same as the register-file WA).
- flush  in  1  discard all outstanding writes.
- busy_vec  out  NUM_REGS  bit r = pending[r] != 0; bit 0 is always 0.
- idle  out  1  no write outstanding anywhere.
- underflow_err  out  1  sticky flag: writeback to a register with no pending write.

Behaviour:
- State: pending[1..NUM_REGS-1], each CNT_W bits; underflow_err register.
- Reset: all counters 0, underflow_err 0. Resulting outputs: busy_vec 0, idle 1, issue_ready 1 unless issue_valid with a blocked condition (impossible at 0), stall 0.
- Reset mid-operation discards all pending state. A wb_valid on the reset cycle is ignored.
- Hazard (combinational):
  - src_hit1 = issue_use_rs1 && issue_rs1!=0 && pending[issue_rs1]!=0.
  - src_hit2 is the same for rs2.
  - sat = issue_wr_en && issue_rd!=0 && pending[issue_rd]==all-ones.
- issue_ready = !flush && !src_hit1 && !src_hit2 && !sat. It is combinational, zero latency.
- Accept = issue_valid && issue_ready. Write-after-write with a non-saturated rd is allowed, not a hazard.
- Same-cycle writeback does not clear the hazard. The register file writes on the edge, so the reader in that cycle would see the old value. The stall drops the next cycle, 1 cycle after wb.
- Counter update at posedge CLK, priority order:
  1. rst.
  2. flush: all counters 0, no other updates.
  3. Per register r != 0: inc = accept && issue_wr_en && issue_rd==r; dec = wb_valid && wb_rd==r && pending[r]!=0.
     - inc && dec: unchanged.
     - inc only: +1.
     - dec only: -1.
- Registers with rd==0 or wb_rd==0 are never counted. A writeback to x0 never raises an error.
- wb_valid && wb_rd!=0 && pending[wb_rd]==0 with no simultaneous inc to that register sets underflow_err. The counter stays 0. underflow_err clears only on rst; flush does not clear it.
- Saturation: a counter never wraps. sat blocks issue until a writeback decrements it.
- busy_vec and idle are decoded from the registered counters, so they update 1 cycle after the edge.

Decomposition:
- Shared package otter_pkg holds:
  - REG_ADDR_W = 5
  - NUM_REGS = 32
  - typedef reg_addr_t (logic [4:0])
  - typedef reg_mask_t (logic [31:0])
- One sub-module, pending_counter: a CNT_W up/down counter with inc, dec, clear, is_zero and is_max. It is instantiated 31 times via generate. The top level holds the hazard logic and the underflow flag.

Test Plan:
- Reset, then idle: rst=1 for 2 cycles → busy_vec=0, idle=1, underflow_err=0. Then issue rs1=5, use_rs1=1 → issue_ready=1.
- RAW stall: issue rd=3, wr_en=1 (accepted). Next cycle issue rs1=3 → stall=1. Keep it stalled while wb_valid=1, wb_rd=3 is applied for 1 cycle; stall stays 1 in that cycle. Next cycle → stall=0, busy_vec[3]=0.
- Saturation: issue rd=7 three times → pending[7]=3. Fourth issue rd=7 → issue_ready=0. One wb_rd=7 → ready=1 the following cycle.
- Simultaneous: pending[4]=1; accept issue rd=4 and wb_rd=4 in the same cycle → busy_vec[4] stays 1. One more wb_rd=4 → busy_vec[4]=0, idle=1.
- x0 and underflow: issue rd=0 → busy_vec=0. wb_rd=0 → no error. wb_rd=9 with pending[9]=0 → underflow_err=1 next cycle, and it stays 1 after a flush.
- Flush mid-operation: pending regs 2, 6, 31 are nonzero. Assert flush together with issue_valid rd=8 → issue_ready=0. Next cycle → busy_vec=0, idle=1, and reg 8 is not busy.
